ysyx_23060191_imem_ctrl: RTL and testbench
==========================================

Name: ysyx_23060191_imem_ctrl

Overview:
Parametrised instruction-memory controller for the NPC fetch path.
- Takes fetch requests over a valid/ready channel.
- Reads the simulated physical memory through the DPI-C function pmem_read after a configurable fixed latency.
- Returns the instruction over a valid/ready response channel, with alignment checking and a flush for redirects.
- Sits between the IFU PC logic and the DPI-C memory model.

Parameters:
ADDR_W, 32, request address width.
DATA_W, 32, instruction width; only 32 is supported because pmem_read returns int.
LATENCY, 1, cycles from request accept to resp_valid; legal range 1..15.
PMEM_BASE, 32'h8000_0000, first valid fetch address. Used only with the optional feature.
PMEM_SIZE, 32'h0800_0000, size of the fetchable region in bytes. Used only with the optional feature.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  drops any in-flight request or held response.
req_valid  input  1  fetch request valid.
req_ready  output  1  controller can accept a request this cycle.
req_addr  input  ADDR_W  fetch address (PC).
resp_valid  output  1  response valid.
resp_ready  input  1  consumer accepts the response.
resp_inst  output  DATA_W  fetched instruction.
resp_err  output  1  fetch fault; resp_inst is 0 when this is set.

Behaviour:
- Reset: the design has one clock; reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, resp_valid=0, resp_inst=0, resp_err=0, counter=0, latched address=0, req_ready=0.
  - Asserting reset mid-operation abandons the request. No pmem_read is issued for it.
- FSM states: IDLE, WAIT, RESP.
- req_ready (combinational):
  - 1 in IDLE.
  - Equal to resp_ready in RESP.
  - 0 in WAIT.
  - 0 whenever flush=1.
- Accept: a request is accepted when req_valid and req_ready are both 1 at a rising edge. On accept:
  - latch req_addr;
  - load counter with LATENCY-1;
  - go to WAIT.
- WAIT:
  - If counter≠0: decrement the counter.
  - If counter=0: perform the read in this edge's sequential block, register the result, go to RESP.
  - Result: resp_valid rises exactly LATENCY cycles after the accept edge.
- Read rules:
  - addr[1:0]≠0: do not call pmem_read; resp_inst=0, resp_err=1.
  - Otherwise: resp_inst=pmem_read(addr), resp_err=0.
  - pmem_read is called exactly once per non-flushed, aligned request, and only from clocked logic.
- RESP:
  - resp_valid=1. resp_inst and resp_err are held stable until the handshake.
  - On resp_ready=1 without a new request: go to IDLE; resp_valid drops next cycle.
  - On resp_ready=1 with req_valid=1 in the same cycle: accept the new request and go directly to WAIT. This gives back-to-back throughput of one fetch per LATENCY+1 cycles.
- Flush (highest priority):
  - In WAIT: return to IDLE and cancel the read. No pmem_read call and no response.
  - In RESP: clear resp_valid, return to IDLE. The response is discarded even if resp_ready=1 in the same cycle.
  - In IDLE: no effect other than holding req_ready=0.
- Counter width: 4 bits. No wrap-around is possible because LATENCY≤15.
- resp_inst and resp_err are not cleared on handshake; they hold their last value while resp_valid=0.

Optional Feature:
Macro: YSYX_23060191_IMEM_RANGE_CHK_EN.
- Defined: an aligned address outside [PMEM_BASE, PMEM_BASE+PMEM_SIZE) is treated like a misaligned one.
  - No pmem_read call.
  - resp_inst=0, resp_err=1, with the same latency as a normal read.
  - The bounds comparison uses ADDR_W+1 bits so that PMEM_BASE+PMEM_SIZE does not overflow.
- Not defined: every aligned address is passed to pmem_read. PMEM_BASE and PMEM_SIZE are unused.

Test Plan:
1. Reset release, LATENCY=1, memory[0x80000000]=0x00000413. Request 0x80000000 with resp_ready=1 → resp_valid high exactly 1 cycle after accept; resp_inst=0x00000413; resp_err=0; exactly one pmem_read call.
2. LATENCY=3. Stream requests 0x80000000, 0x80000004, 0x80000008 with resp_ready held at 1 → each response arrives 3 cycles after its accept; accepts fall on consecutive RESP cycles; data appears in order.
3. Request 0x80000002 → after LATENCY cycles resp_err=1 and resp_inst=0; no pmem_read call.
4. LATENCY=4. Assert flush 2 cycles after accept → no resp_valid and no pmem_read. A following request to 0x80000010 completes normally.
5. Hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_inst stay stable and req_ready=0. Then drop rst_n mid-WAIT on the next request → all outputs go to 0 immediately.
6. Macro defined, PMEM_SIZE=0x1000. Request 0x80001000 → resp_err=1; no pmem_read. Request 0x80000FFC → normal read.

Source files
------------

// File: rtl/ysyx_23060191_imem_ctrl_if.sv
// Fetch request/response bundle between IFU and imem controller.
// pmem_read is a local SV model of the physical memory.
interface ysyx_23060191_imem_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_inst;
    logic              resp_err;

    logic [31:0] pmem [1024];
    int unsigned rd_cnt;

    function automatic int pmem_read(input int raddr);
        rd_cnt = rd_cnt + 1;
        return int'(pmem[raddr[11:2]]);
    endfunction

    modport master (
        output flush,
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_inst,
        input  resp_err
    );

    modport slave (
        input  flush,
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_inst,
        output resp_err,
        import pmem_read
    );
endinterface

// File: rtl/ysyx_23060191_imem_ctrl.sv
// Fixed-latency instruction fetch controller in front of pmem_read.
// Define YSYX_23060191_IMEM_RANGE_CHK_EN to fault fetches outside pmem.
module ysyx_23060191_imem_ctrl #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       LATENCY   = 1,
    parameter logic [ADDR_W-1:0] PMEM_BASE = 32'h8000_0000,
    parameter logic [ADDR_W-1:0] PMEM_SIZE = 32'h0800_0000
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_23060191_imem_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

`ifdef YSYX_23060191_IMEM_RANGE_CHK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic [DATA_W-1:0] inst_q;
    logic              err_q;

    logic [ADDR_W:0] addr_ext;
    logic [ADDR_W:0] lo_ext;
    logic [ADDR_W:0] hi_ext;
    logic            aligned;
    logic            in_range;
    logic            fetch_ok;

    // One extra bit so BASE+SIZE cannot wrap.
    assign addr_ext = {1'b0, addr_q};
    assign lo_ext   = {1'b0, PMEM_BASE};
    assign hi_ext   = lo_ext + {1'b0, PMEM_SIZE};

    assign aligned  = (addr_q[1:0] == 2'b00);
    assign in_range = (addr_ext >= lo_ext)
                   && (addr_ext < hi_ext);
    assign fetch_ok = aligned
                   && (in_range || !RANGE_EN);

    always_comb begin
        bus.req_ready = 1'b0;
        if (rst_n && !bus.flush) begin
            unique case (state_q)
                IDLE:    bus.req_ready = 1'b1;
                RESP:    bus.req_ready = bus.resp_ready;
                default: bus.req_ready = 1'b0;
            endcase
        end
    end

    assign bus.resp_valid = valid_q;
    assign bus.resp_inst  = inst_q;
    assign bus.resp_err   = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        cnt_q   <= CNT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= RESP;
                        if (fetch_ok) begin
                            inst_q <= DATA_W'(
                                bus.pmem_read(int'(addr_q)));
                            err_q  <= 1'b0;
                        end else begin
                            inst_q <= '0;
                            err_q  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        valid_q <= 1'b0;
                        if (bus.req_valid) begin
                            addr_q  <= bus.req_addr;
                            cnt_q   <= CNT_INIT;
                            state_q <= WAIT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060191_imem_ctrl.sv
// Scoreboard bench for ysyx_23060191_imem_ctrl at LATENCY 1, 3 and 4.
// Honours YSYX_23060191_IMEM_RANGE_CHK_EN in its expectations.
module tb_ysyx_23060191_imem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        resp_ready = 1'b0;
    logic [31:0] req_addr = '0;
    int          sel = 0;

    always #5 clk = ~clk;

    ysyx_23060191_imem_ctrl_if b1 ();
    ysyx_23060191_imem_ctrl_if b3 ();
    ysyx_23060191_imem_ctrl_if b4 ();

    assign b1.flush      = flush;
    assign b1.req_valid  = req_valid && (sel == 0);
    assign b1.req_addr   = req_addr;
    assign b1.resp_ready = resp_ready;
    assign b3.flush      = flush;
    assign b3.req_valid  = req_valid && (sel == 1);
    assign b3.req_addr   = req_addr;
    assign b3.resp_ready = resp_ready;
    assign b4.flush      = flush;
    assign b4.req_valid  = req_valid && (sel == 2);
    assign b4.req_addr   = req_addr;
    assign b4.resp_ready = resp_ready;

    ysyx_23060191_imem_ctrl #(.LATENCY(1)) d1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));
    ysyx_23060191_imem_ctrl #(.LATENCY(3)) d3 (
        .clk(clk), .rst_n(rst_n), .bus(b3));
    ysyx_23060191_imem_ctrl #(
        .LATENCY(4),
        .PMEM_SIZE(32'h0000_1000)
    ) d4 (
        .clk(clk), .rst_n(rst_n), .bus(b4));

    logic        o_rr, o_rv, o_err;
    logic [31:0] o_inst;

    always_comb begin
        o_rr   = b1.req_ready;
        o_rv   = b1.resp_valid;
        o_inst = b1.resp_inst;
        o_err  = b1.resp_err;
        if (sel == 1) begin
            o_rr   = b3.req_ready;
            o_rv   = b3.resp_valid;
            o_inst = b3.resp_inst;
            o_err  = b3.resp_err;
        end else if (sel == 2) begin
            o_rr   = b4.req_ready;
            o_rv   = b4.resp_valid;
            o_inst = b4.resp_inst;
            o_err  = b4.resp_err;
        end
    end

    typedef struct {
        logic [31:0] inst;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;
    logic prev_rv = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 3 : 4);
    endfunction

    function automatic logic [31:0] size_of(input int s);
        return (s == 2) ? 32'h0000_1000 : 32'h0800_0000;
    endfunction

    function automatic logic [31:0] memword(input logic [9:0] i);
        if (i == 10'd0) return 32'h0000_0413;
        return {i, 10'h0, 12'h093};
    endfunction

    function automatic logic exp_err(input logic [31:0] a,
                                     input int s);
        logic e;
        e = (a[1:0] != 2'b00);
`ifdef YSYX_23060191_IMEM_RANGE_CHK_EN
        begin
            logic [32:0] ae, lo, hi;
            ae = {1'b0, a};
            lo = 33'h0_8000_0000;
            hi = lo + {1'b0, size_of(s)};
            if (ae < lo || ae >= hi) e = 1'b1;
        end
`else
        if (s < 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] exp_inst(input logic [31:0] a,
                                             input int s);
        return exp_err(a, s) ? 32'h0 : memword(a[11:2]);
    endfunction

    function automatic int unsigned rdc();
        return b1.rd_cnt + b3.rd_cnt + b4.rd_cnt;
    endfunction

    // One clock: predict from pre-edge inputs, check after the edge.
    task automatic step(output bit acc);
        bit   hs;
        exp_t e;
        acc = req_valid && o_rr;
        hs  = o_rv && resp_ready && !flush;
        @(posedge clk);
        cyc++;
        if (flush || !rst_n) begin
            sb.delete();
        end else begin
            if (hs && sb.size() > 0) void'(sb.pop_front());
            if (acc) begin
                e.inst = exp_inst(req_addr, sel);
                e.err  = exp_err(req_addr, sel);
                e.due  = cyc + lat_of(sel);
                sb.push_back(e);
            end
        end
        @(negedge clk);
        if (o_rv) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(o_rv), 32'h0);
            end else begin
                if (!prev_rv) check("latency", cyc, sb[0].due);
                check("inst", o_inst, sb[0].inst);
                check("err", 32'(o_err), 32'(sb[0].err));
            end
        end
        prev_rv = o_rv;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic issue(input logic [31:0] a, output int at);
        bit acc;
        req_valid = 1'b1;
        req_addr  = a;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            step(acc);
            if (acc) begin
                at = cyc;
                break;
            end
        end
        req_valid = 1'b0;
        if (at < 0) check("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while ((sb.size() != 0 || o_rv) && n < 40) begin
            step(acc);
            n++;
        end
        if (n >= 40) check("drain_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int at0, at1, at2;
        int unsigned r0;
        bit acc;
        int n;

        for (int i = 0; i < 1024; i++) begin
            b1.pmem[i] = memword(10'(i));
            b3.pmem[i] = memword(10'(i));
            b4.pmem[i] = memword(10'(i));
        end

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(o_rv), 32'h0);
        check("rst_inst", o_inst, 32'h0);
        check("rst_err", 32'(o_err), 32'h0);
        check("rst_ready", 32'(o_rr), 32'h0);
        rst_n = 1'b1;
        #1;
        check("idle_ready", 32'(o_rr), 32'h1);

        sel = 0;
        resp_ready = 1'b1;
        r0 = rdc();
        issue(32'h8000_0000, at0);
        drain();
        check("t1_reads", rdc() - r0, 32'd1);

        sel = 1;
        r0 = rdc();
        issue(32'h8000_0000, at0);
        issue(32'h8000_0004, at1);
        issue(32'h8000_0008, at2);
        drain();
        check("t2_gap1", at1 - at0, 32'd4);
        check("t2_gap2", at2 - at1, 32'd4);
        check("t2_reads", rdc() - r0, 32'd3);

        r0 = rdc();
        issue(32'h8000_0002, at0);
        drain();
        check("t3_reads", rdc() - r0, 32'd0);

        sel = 2;
        r0 = rdc();
        issue(32'h8000_0000, at0);
        step(acc);
        flush = 1'b1;
        #1;
        check("flush_ready", 32'(o_rr), 32'h0);
        step(acc);
        flush = 1'b0;
        idle(6);
        check("t4_flush_reads", rdc() - r0, 32'd0);
        issue(32'h8000_0010, at0);
        drain();
        check("t4_reads", rdc() - r0, 32'd1);

        sel = 1;
        resp_ready = 1'b0;
        r0 = rdc();
        issue(32'h8000_0004, at0);
        n = 0;
        while (!o_rv && n < 20) begin
            step(acc);
            n++;
        end
        check("t5_valid", 32'(o_rv), 32'h1);
        req_valid = 1'b1;
        req_addr  = 32'h8000_0008;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_hold_ready", 32'(o_rr), 32'h0);
            step(acc);
        end
        resp_ready = 1'b1;
        step(acc);
        req_valid = 1'b0;
        step(acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(o_rv), 32'h0);
        check("t5_rst_inst", o_inst, 32'h0);
        check("t5_rst_err", 32'(o_err), 32'h0);
        check("t5_rst_ready", 32'(o_rr), 32'h0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        prev_rv = o_rv;
        idle(6);
        check("t5_reads", rdc() - r0, 32'd1);

        sel = 2;
        r0 = rdc();
        issue(32'h8000_1000, at0);
        drain();
        check("t6_out_reads", rdc() - r0,
              exp_err(32'h8000_1000, 2) ? 32'd0 : 32'd1);
        r0 = rdc();
        issue(32'h8000_0FFC, at0);
        drain();
        check("t6_in_reads", rdc() - r0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
